// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared constants for the serial add/subtract unit:
//   - operation mode encodings (MODE_ADD, MODE_SUB)
//   - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE)
//   - helper function for signed two's-complement overflow detection
package serial_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Subtraction adds the inverted B operand, so flipping B's sign bit by
  // mode turns both the add and subtract overflow rules into one test:
  // effective operands agree in sign but the result sign differs.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic r_msb,
                                           input logic mode);
    return (a_msb == (b_msb ^ mode)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if
//   Request/response bundle of the serial add/subtract unit.
//   Requester side (master): start, mode, a_in, b_in.
//   Unit side (slave):       busy, done, result, carry_out, overflow,
//                            zero, negative.
//   WIDTH must match the WIDTH of the serial_addsub it connects to.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, mode, a_in, b_in,
    input  busy, done, result, carry_out, overflow, zero, negative
  );

  modport slave (
    input  start, mode, a_in, b_in,
    output busy, done, result, carry_out, overflow, zero, negative
  );

endinterface

// File: rtl/serial_addsub_chunk.sv
// addsub_chunk
//   Purely combinational CHUNK-bit add/subtract slice.
//   Ports:
//     a, b  : CHUNK-bit operand slices
//     mode  : 0 = add, 1 = subtract (B slice is inverted)
//     cin   : carry into this slice
//     sum   : low CHUNK bits of a + (b ^ mode) + cin
//     cout  : carry out of this slice
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b ^ {CHUNK{mode}}} + {{CHUNK{1'b0}}, cin};
  assign sum      = full_sum[CHUNK-1:0];
  assign cout     = full_sum[CHUNK];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Multi-cycle add/subtract unit processing CHUNK bits per clock, LSB first.
//   An accepted request (start while not running) latches operands and mode;
//   NCHUNK clocks later the result and flags update together with a one-cycle
//   done pulse. Outputs hold their values until the next completion.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : serial_addsub_if slave modport (start/mode/a_in/b_in in,
//             busy/done/result/carry_out/overflow/zero/negative out)
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             mode_r;
  logic             carry_r;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] res_next;

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .mode (mode_r),
    .cin  (carry_r),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the top so that after NCHUNK shifts the first chunk
  // has reached bit 0. Written as shifts so CHUNK == WIDTH needs no slicing.
  assign res_next = (res_sh >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  // Sequencer and datapath: accept in IDLE or DONE, one chunk per RUN edge,
  // publish result and flags on the last chunk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      mode_r      <= MODE_ADD;
      carry_r     <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh    <= bus.a_in;
            b_sh    <= bus.b_in;
            a_msb   <= bus.a_in[WIDTH-1];
            b_msb   <= bus.b_in[WIDTH-1];
            mode_r  <= bus.mode;
            carry_r <= bus.mode;
            cnt     <= '0;
            res_sh  <= '0;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          res_sh  <= res_next;
          carry_r <= chunk_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state       <= ST_DONE;
            result_r    <= res_next;
            carry_out_r <= chunk_cout ^ mode_r;
            overflow_r  <= signed_overflow(a_msb, b_msb, res_next[WIDTH-1], mode_r);
            zero_r      <= (res_next == '0);
            negative_r  <= res_next[WIDTH-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.negative  = negative_r;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Directed bench for serial_addsub in three configurations:
//   sel 0: WIDTH=8  CHUNK=4, sel 1: WIDTH=8 CHUNK=1, sel 2: WIDTH=16 CHUNK=8.
//   Inputs change and outputs are sampled on the falling clock edge.
//   Flag vectors are packed as {carry_out, overflow, zero, negative}.
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic        obs_busy;
  logic        obs_done;
  logic [15:0] obs_result;
  logic [3:0]  obs_flags;

  serial_addsub_if #(.WIDTH(8))  if4 ();
  serial_addsub_if #(.WIDTH(8))  if1 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  serial_addsub #(.WIDTH(8),  .CHUNK(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_addsub #(.WIDTH(8),  .CHUNK(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_addsub #(.WIDTH(16), .CHUNK(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic st, input logic m,
                               input logic [15:0] a, input logic [15:0] b);
    case (sel)
      0: begin
        if4.start = st; if4.mode = m; if4.a_in = a[7:0]; if4.b_in = b[7:0];
      end
      1: begin
        if1.start = st; if1.mode = m; if1.a_in = a[7:0]; if1.b_in = b[7:0];
      end
      default: begin
        if16.start = st; if16.mode = m; if16.a_in = a; if16.b_in = b;
      end
    endcase
  endtask

  task automatic sampleOutputs(input int sel);
    case (sel)
      0: begin
        obs_busy   = if4.busy;
        obs_done   = if4.done;
        obs_result = {8'h00, if4.result};
        obs_flags  = {if4.carry_out, if4.overflow, if4.zero, if4.negative};
      end
      1: begin
        obs_busy   = if1.busy;
        obs_done   = if1.done;
        obs_result = {8'h00, if1.result};
        obs_flags  = {if1.carry_out, if1.overflow, if1.zero, if1.negative};
      end
      default: begin
        obs_busy   = if16.busy;
        obs_done   = if16.done;
        obs_result = if16.result;
        obs_flags  = {if16.carry_out, if16.overflow, if16.zero, if16.negative};
      end
    endcase
  endtask

  // One complete operation: pulse start, wait (bounded) for done, check
  // latency, result, flags, and that busy is low during the done cycle.
  task automatic runOp(input int sel, input string tag, input logic m,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input logic [3:0] exp_flags,
                       input int exp_lat);
    int cyc;
    applyStimulus(sel, 1'b1, m, a, b);
    @(negedge clk);
    applyStimulus(sel, 1'b0, m, a, b);
    cyc = 0;
    sampleOutputs(sel);
    while (!obs_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      sampleOutputs(sel);
    end
    checkOutput({tag, "_done"},   32'(obs_done),   32'd1);
    checkOutput({tag, "_lat"},    32'(cyc),        32'(exp_lat));
    checkOutput({tag, "_result"}, 32'(obs_result), 32'(exp_res));
    checkOutput({tag, "_flags"},  32'(obs_flags),  32'(exp_flags));
    checkOutput({tag, "_busy"},   32'(obs_busy),   32'd0);
  endtask

  initial begin
    logic [5:0] busy_trace;
    logic [5:0] done_trace;
    int         stray_done;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(2, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset state
    repeat (2) @(negedge clk);
    sampleOutputs(0);
    checkOutput("rst_busy",   32'(obs_busy),   32'd0);
    checkOutput("rst_done",   32'(obs_done),   32'd0);
    checkOutput("rst_result", 32'(obs_result), 32'd0);
    checkOutput("rst_flags",  32'(obs_flags),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add/subtract vectors, WIDTH=8 CHUNK=4
    runOp(0, "sub_05_03", 1'b1, 16'h05, 16'h03, 16'h02, 4'b0000, 2);
    runOp(0, "sub_03_05", 1'b1, 16'h03, 16'h05, 16'hFE, 4'b1001, 2);
    runOp(0, "sub_80_01", 1'b1, 16'h80, 16'h01, 16'h7F, 4'b0100, 2);
    runOp(0, "add_7F_01", 1'b0, 16'h7F, 16'h01, 16'h80, 4'b0101, 2);
    runOp(0, "add_FF_01", 1'b0, 16'hFF, 16'h01, 16'h00, 4'b1010, 2);

    // Hold during RUN, operand immunity, start ignored while running
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 16'h01, 16'h01);
    @(negedge clk);
    checkOutput("hold_result_run0", 32'(if4.result), 32'h00);
    checkOutput("hold_zero_run0",   32'(if4.zero),   32'd1);
    applyStimulus(0, 1'b1, 1'b1, 16'hAA, 16'h55);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 16'hAA, 16'h55);
    checkOutput("hold_busy_run1",   32'(if4.busy),   32'd1);
    checkOutput("hold_result_run1", 32'(if4.result), 32'h00);
    @(negedge clk);
    checkOutput("hold_done",   32'(if4.done),   32'd1);
    checkOutput("hold_result", 32'(if4.result), 32'h02);
    @(negedge clk);
    checkOutput("ignored_busy", 32'(if4.busy), 32'd0);
    checkOutput("ignored_done", 32'(if4.done), 32'd0);

    // Back-to-back: start held high, second op accepted in the DONE cycle
    applyStimulus(0, 1'b1, 1'b1, 16'h05, 16'h03);
    busy_trace = '0;
    done_trace = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_trace = {busy_trace[4:0], if4.busy};
      done_trace = {done_trace[4:0], if4.done};
      if (i == 0) applyStimulus(0, 1'b1, 1'b0, 16'h10, 16'h20);
      if (i == 2) checkOutput("b2b_first_result", 32'(if4.result), 32'h02);
      if (i == 3) applyStimulus(0, 1'b0, 1'b0, 16'h10, 16'h20);
    end
    checkOutput("b2b_busy_trace",    32'(busy_trace), 32'b110110);
    checkOutput("b2b_done_trace",    32'(done_trace), 32'b001001);
    checkOutput("b2b_second_result", 32'(if4.result), 32'h30);
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse
    applyStimulus(0, 1'b1, 1'b0, 16'h7F, 16'h01);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 16'h7F, 16'h01);
    rst_n = 1'b0;
    #1;
    sampleOutputs(0);
    checkOutput("abort_busy",   32'(obs_busy),   32'd0);
    checkOutput("abort_result", 32'(obs_result), 32'd0);
    checkOutput("abort_flags",  32'(obs_flags),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if4.done !== 1'b0 || if4.busy !== 1'b0) stray_done++;
    end
    checkOutput("abort_no_done", 32'(stray_done), 32'd0);
    runOp(0, "post_abort_add", 1'b0, 16'h7F, 16'h01, 16'h80, 4'b0101, 2);

    // Bit-serial configuration, WIDTH=8 CHUNK=1
    @(negedge clk);
    runOp(1, "c1_sub_10_10", 1'b1, 16'h10, 16'h10, 16'h00, 4'b0010, 8);
    runOp(1, "c1_sub_03_05", 1'b1, 16'h03, 16'h05, 16'hFE, 4'b1001, 8);

    // Wide configuration, WIDTH=16 CHUNK=8
    runOp(2, "w16_add", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 4'b0000, 2);
    runOp(2, "w16_sub", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100, 2);

    $display("[TB] directed sequence complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
